// File: rtl/board_io_ctrl.sv
// Board-level I/O conditioner: button sync/debounce with edge pulses,
// stretched system-reset generator and per-LED mode control.
module board_io_ctrl #(
  parameter int unsigned N_BTN          = 2,
  parameter bit          BTN_ACTIVE_LOW = 1'b1,
  parameter int unsigned DEB_CYCLES     = 500000,
  parameter bit          RST_EN         = 1'b1,
  parameter int unsigned RST_BTN        = 0,
  parameter int unsigned POR_CYCLES     = 1024,
  parameter int unsigned N_LED          = 2,
  parameter int unsigned BLINK_DIV      = 12500000
) (
  input  logic                 CLK_50MHZ,
  input  logic                 nRESET,
  input  logic [N_BTN-1:0]     BTN,
  output logic [N_BTN-1:0]     BTN_LEVEL,
  output logic [N_BTN-1:0]     BTN_PRESS,
  output logic [N_BTN-1:0]     BTN_RELEASE,
  output logic                 SYS_RST,
  input  logic [N_LED-1:0]     LED_IN,
  input  logic [2*N_LED-1:0]   LED_MODE,
  output logic [N_LED-1:0]     LED
);

  localparam int unsigned DebW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam logic [DebW-1:0] DebLast = DebW'(DEB_CYCLES - 1);

  localparam int unsigned RstW = $clog2(POR_CYCLES + 1);
  localparam logic [RstW-1:0] RstLast = RstW'(POR_CYCLES);

  localparam int unsigned BlkW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [BlkW-1:0] BlkLast = BlkW'(BLINK_DIV - 1);

  // Button synchroniser and debounce state
  logic [N_BTN-1:0]            sync1_q, sync2_q;
  logic [N_BTN-1:0][DebW-1:0]  deb_cnt_q, deb_cnt_d;
  logic [N_BTN-1:0]            level_q, level_d;
  logic [N_BTN-1:0]            press_q, press_d;
  logic [N_BTN-1:0]            release_q, release_d;

  // Reset generator state
  logic [RstW-1:0]             rst_cnt_q, rst_cnt_d;
  logic [RstW-1:0]             rst_cnt_inc;
  logic                        sys_rst_q, sys_rst_d;
  logic                        rst_src;

  // Blink timebase and LED drive
  logic [BlkW-1:0]             blk_cnt_q, blk_cnt_d;
  logic                        phase_q, phase_d;
  logic                        blk_wrap;
  logic [N_LED-1:0]            led_q, led_d;

  // Two-flop synchroniser; values are stored normalised so 1 = pressed.
  always_ff @(posedge CLK_50MHZ or negedge nRESET) begin
    if (!nRESET) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= BTN ^ {N_BTN{BTN_ACTIVE_LOW}};
      sync2_q <= sync1_q;
    end
  end

  // Debounce: count consecutive differing cycles, toggle the level on the last one.
  always_comb begin
    deb_cnt_d = '0;
    level_d   = level_q;
    press_d   = '0;
    release_d = '0;
    for (int i = 0; i < N_BTN; i++) begin
      if (sync2_q[i] != level_q[i]) begin
        if (deb_cnt_q[i] == DebLast) begin
          level_d[i]   = ~level_q[i];
          press_d[i]   = ~level_q[i];
          release_d[i] = level_q[i];
        end else begin
          deb_cnt_d[i] = deb_cnt_q[i] + 1'b1;
        end
      end
    end
  end

  // Debounce counters, debounced level and edge pulses
  always_ff @(posedge CLK_50MHZ or negedge nRESET) begin
    if (!nRESET) begin
      deb_cnt_q <= '0;
      level_q   <= '0;
      press_q   <= '0;
      release_q <= '0;
    end else begin
      deb_cnt_q <= deb_cnt_d;
      level_q   <= level_d;
      press_q   <= press_d;
      release_q <= release_d;
    end
  end

  // The source covers the edge the level rises (so SYS_RST rises with it) through the
  // edge it falls, so the stretch is counted from the edge after the level drops.
  assign rst_src     = RST_EN && (level_d[RST_BTN] || level_q[RST_BTN]);
  assign rst_cnt_inc = rst_cnt_q + 1'b1;

  // Reset stretch next-state
  always_comb begin
    rst_cnt_d = rst_cnt_q;
    sys_rst_d = sys_rst_q;
    if (rst_src) begin
      rst_cnt_d = '0;
      sys_rst_d = 1'b1;
    end else if (sys_rst_q) begin
      rst_cnt_d = rst_cnt_inc;
      if (rst_cnt_inc == RstLast) begin
        sys_rst_d = 1'b0;
      end
    end
  end

  // Reset stretch registers; only nRESET resets this block
  always_ff @(posedge CLK_50MHZ or negedge nRESET) begin
    if (!nRESET) begin
      rst_cnt_q <= '0;
      sys_rst_q <= 1'b1;
    end else begin
      rst_cnt_q <= rst_cnt_d;
      sys_rst_q <= sys_rst_d;
    end
  end

  // Free-running blink timebase, phase toggles on each wrap
  always_comb begin
    blk_wrap  = (blk_cnt_q == BlkLast);
    blk_cnt_d = blk_wrap ? '0 : blk_cnt_q + 1'b1;
    phase_d   = phase_q ^ blk_wrap;
  end

  // Per-LED mode decode
  always_comb begin
    led_d = '0;
    for (int i = 0; i < N_LED; i++) begin
      unique case (LED_MODE[2*i +: 2])
        2'b00: led_d[i] = LED_IN[i];
        2'b01: led_d[i] = ~LED_IN[i];
        2'b10: led_d[i] = LED_IN[i] & phase_q;
        2'b11: led_d[i] = 1'b0;
      endcase
    end
  end

  // Blink counter, phase and registered LED drive
  always_ff @(posedge CLK_50MHZ or negedge nRESET) begin
    if (!nRESET) begin
      blk_cnt_q <= '0;
      phase_q   <= 1'b0;
      led_q     <= '0;
    end else begin
      blk_cnt_q <= blk_cnt_d;
      phase_q   <= phase_d;
      led_q     <= led_d;
    end
  end

  assign BTN_LEVEL   = level_q;
  assign BTN_PRESS   = press_q;
  assign BTN_RELEASE = release_q;
  assign SYS_RST     = sys_rst_q;
  assign LED         = led_q;

endmodule

// File: tb/tb_board_io_ctrl.sv
// Directed testbench for board_io_ctrl with small debounce/stretch/blink constants.
module tb_board_io_ctrl;

  logic       clk;
  logic       nrst;
  logic [1:0] btn;
  logic [1:0] btn_level;
  logic [1:0] btn_press;
  logic [1:0] btn_release;
  logic       sys_rst;
  logic [1:0] led_in;
  logic [3:0] led_mode;
  logic [1:0] led;

  int checks;
  int errors;
  int edges;  // rising edges since nRESET was released, for the blink reference

  board_io_ctrl #(
    .N_BTN         (2),
    .BTN_ACTIVE_LOW(1'b1),
    .DEB_CYCLES    (4),
    .RST_EN        (1'b1),
    .RST_BTN       (0),
    .POR_CYCLES    (8),
    .N_LED         (2),
    .BLINK_DIV     (3)
  ) dut (
    .CLK_50MHZ  (clk),
    .nRESET     (nrst),
    .BTN        (btn),
    .BTN_LEVEL  (btn_level),
    .BTN_PRESS  (btn_press),
    .BTN_RELEASE(btn_release),
    .SYS_RST    (sys_rst),
    .LED_IN     (led_in),
    .LED_MODE   (led_mode),
    .LED        (led)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk or negedge nrst) begin
    if (!nrst) edges <= 0;
    else       edges <= edges + 1;
  end

  // Advance to the next falling edge: outputs are sampled and inputs driven there.
  task automatic step;
    @(negedge clk);
  endtask

  task automatic test_reset;
    repeat (3) step;
    checks++;
    if (sys_rst !== 1'b1) begin
      errors++; $display("FAIL rst_sys_rst got %b exp 1", sys_rst);
    end
    checks++;
    if ({btn_level, btn_press, btn_release} !== 6'b0) begin
      errors++; $display("FAIL rst_btn_outs got %b exp 000000",
                         {btn_level, btn_press, btn_release});
    end
    checks++;
    if (led !== 2'b00) begin
      errors++; $display("FAIL rst_led got %b exp 00", led);
    end
    nrst = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      step;
      checks++;
      if (sys_rst !== (k < 8)) begin
        errors++; $display("FAIL por_sys_rst edge=%0d got %b exp %b", k, sys_rst, (k < 8));
      end
      checks++;
      if (btn_level !== 2'b00 || led !== 2'b00) begin
        errors++; $display("FAIL por_level_led edge=%0d got %b/%b exp 00/00", k, btn_level, led);
      end
    end
  endtask

  task automatic test_clean_press;
    btn = 2'b01;
    for (int k = 1; k <= 8; k++) begin
      step;
      checks++;
      if (btn_level !== {(k >= 6), 1'b0} || btn_press !== {(k == 6), 1'b0}
          || btn_release !== 2'b00) begin
        errors++; $display("FAIL press edge=%0d got lvl=%b prs=%b rel=%b exp lvl=%b prs=%b rel=00",
                           k, btn_level, btn_press, btn_release, {(k >= 6), 1'b0},
                           {(k == 6), 1'b0});
      end
    end
    btn = 2'b11;
    for (int k = 1; k <= 8; k++) begin
      step;
      checks++;
      if (btn_level !== {(k < 6), 1'b0} || btn_release !== {(k == 6), 1'b0}
          || btn_press !== 2'b00) begin
        errors++; $display("FAIL release edge=%0d got lvl=%b prs=%b rel=%b exp lvl=%b prs=00 rel=%b",
                           k, btn_level, btn_press, btn_release, {(k < 6), 1'b0},
                           {(k == 6), 1'b0});
      end
    end
    checks++;
    if (sys_rst !== 1'b0) begin
      errors++; $display("FAIL press_sys_rst got %b exp 0", sys_rst);
    end
  endtask

  task automatic test_bounce;
    logic [1:0] pattern [8];
    pattern = '{2'b01, 2'b01, 2'b01, 2'b11, 2'b01, 2'b01, 2'b01, 2'b11};
    for (int k = 0; k < 20; k++) begin
      btn = (k < 8) ? pattern[k] : 2'b11;
      step;
      checks++;
      if (btn_level !== 2'b00 || btn_press !== 2'b00 || btn_release !== 2'b00) begin
        errors++; $display("FAIL bounce cyc=%0d got lvl=%b prs=%b rel=%b exp 00/00/00",
                           k, btn_level, btn_press, btn_release);
      end
    end
  endtask

  task automatic test_reset_button;
    btn = 2'b10;
    for (int k = 1; k <= 20; k++) begin
      step;
      checks++;
      if (sys_rst !== (k >= 6) || btn_level[0] !== (k >= 6)) begin
        errors++; $display("FAIL rstbtn_hold edge=%0d got rst=%b lvl0=%b exp %b",
                           k, sys_rst, btn_level[0], (k >= 6));
      end
    end
    btn = 2'b11;
    for (int k = 1; k <= 16; k++) begin
      step;
      checks++;
      if (sys_rst !== (k < 14) || btn_level[0] !== (k < 6) || btn_release[0] !== (k == 6)) begin
        errors++; $display("FAIL rstbtn_stretch edge=%0d got rst=%b lvl0=%b rel0=%b exp %b %b %b",
                           k, sys_rst, btn_level[0], btn_release[0], (k < 14), (k < 6), (k == 6));
      end
    end
  endtask

  task automatic test_reset_repress;
    btn = 2'b10;
    for (int k = 1; k <= 10; k++) begin
      step;
      checks++;
      if (sys_rst !== (k >= 6)) begin
        errors++; $display("FAIL repress_hold edge=%0d got %b exp %b", k, sys_rst, (k >= 6));
      end
    end
    btn = 2'b11;
    // Level falls at edge 6; re-press so it rises again at edge 12, where the countdown is 5.
    for (int k = 1; k <= 16; k++) begin
      step;
      checks++;
      if (sys_rst !== 1'b1 || btn_level[0] !== ((k < 6) || (k >= 12))) begin
        errors++; $display("FAIL repress_mid edge=%0d got rst=%b lvl0=%b exp 1 %b",
                           k, sys_rst, btn_level[0], ((k < 6) || (k >= 12)));
      end
      if (k == 6) btn = 2'b10;
    end
    btn = 2'b11;
    for (int k = 1; k <= 16; k++) begin
      step;
      checks++;
      if (sys_rst !== (k < 14) || btn_level[0] !== (k < 6)) begin
        errors++; $display("FAIL repress_stretch edge=%0d got rst=%b lvl0=%b exp %b %b",
                           k, sys_rst, btn_level[0], (k < 14), (k < 6));
      end
    end
  endtask

  task automatic test_led_modes;
    logic [1:0] exp;
    led_in   = 2'b11;
    led_mode = 4'b0000;
    #1;
    checks++;
    if (led !== 2'b00) begin
      errors++; $display("FAIL led_m00_latency got %b exp 00", led);
    end
    step;
    checks++;
    if (led !== 2'b11) begin
      errors++; $display("FAIL led_m00 got %b exp 11", led);
    end
    led_mode = 4'b0101;
    #1;
    checks++;
    if (led !== 2'b11) begin
      errors++; $display("FAIL led_m01_latency got %b exp 11", led);
    end
    step;
    checks++;
    if (led !== 2'b00) begin
      errors++; $display("FAIL led_m01 got %b exp 00", led);
    end
    led_mode = 4'b1010;
    for (int k = 1; k <= 12; k++) begin
      step;
      exp = ((((edges - 1) / 3) % 2) == 1) ? 2'b11 : 2'b00;
      checks++;
      if (led !== exp) begin
        errors++; $display("FAIL led_m10 edge=%0d got %b exp %b", edges, led, exp);
      end
    end
    led_mode = 4'b1111;
    for (int k = 1; k <= 4; k++) begin
      step;
      checks++;
      if (led !== 2'b00) begin
        errors++; $display("FAIL led_m11 step=%0d got %b exp 00", k, led);
      end
    end
  endtask

  task automatic test_async_reset;
    led_mode = 4'b0000;
    btn = 2'b10;
    for (int k = 1; k <= 8; k++) step;
    btn = 2'b11;
    for (int k = 1; k <= 6; k++) step;  // level0 has fallen, stretch is counting
    btn = 2'b01;
    step;
    step;  // BTN[1] two cycles into its press
    checks++;
    if (sys_rst !== 1'b1 || led !== 2'b11) begin
      errors++; $display("FAIL async_pre got rst=%b led=%b exp 1 11", sys_rst, led);
    end
    nrst = 1'b0;
    #1;
    checks++;
    if (sys_rst !== 1'b1 || btn_level !== 2'b00 || btn_press !== 2'b00
        || btn_release !== 2'b00 || led !== 2'b00) begin
      errors++; $display("FAIL async_rst got rst=%b lvl=%b prs=%b rel=%b led=%b exp 1 00 00 00 00",
                         sys_rst, btn_level, btn_press, btn_release, led);
    end
    step;
    nrst = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      step;
      checks++;
      if (btn_level !== {(k >= 6), 1'b0} || btn_press !== {(k == 6), 1'b0}) begin
        errors++; $display("FAIL async_deb edge=%0d got lvl=%b prs=%b exp %b %b",
                           k, btn_level, btn_press, {(k >= 6), 1'b0}, {(k == 6), 1'b0});
      end
      checks++;
      if (sys_rst !== (k < 8) || led !== 2'b11) begin
        errors++; $display("FAIL async_por edge=%0d got rst=%b led=%b exp %b 11",
                           k, sys_rst, led, (k < 8));
      end
    end
    btn = 2'b11;
    repeat (10) step;
  endtask

  initial begin
    checks   = 0;
    errors   = 0;
    nrst     = 1'b0;
    btn      = 2'b11;
    led_in   = 2'b00;
    led_mode = 4'b0000;
    test_reset;
    test_clean_press;
    test_bounce;
    test_reset_button;
    test_reset_repress;
    test_led_modes;
    test_async_reset;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
